bus_master_arbiter: RTL
=======================

BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, width of every address port.
REQ-002 Parameter DATA_WIDTH, default 32, width of every data port.
REQ-003 Parameter READ_LATENCY, default 1, legal range 1..7, number of cycles from the bus address cycle to valid bus_data_i.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 reset_i  input  1  synchronous active-high reset.
REQ-007 mN_req_i  input  1  (N=0,1) transaction request; held high with mN_we_i/mN_addr_i/mN_wdata_i stable until mN_gnt_o.
REQ-008 mN_we_i  input  1  1 = write, 0 = read.
REQ-009 mN_addr_i  input  ADDRESS_WIDTH  target address.
REQ-010 mN_wdata_i  input  DATA_WIDTH  write data.
REQ-011 mN_gnt_o  output  1  one-cycle pulse: the request is on the bus this cycle.
REQ-012 mN_rvalid_o  output  1  one-cycle pulse: mN_rdata_o holds read data.
REQ-013 mN_rdata_o  output  DATA_WIDTH  captured read data; holds its value until the next capture.
REQ-014 address_o  output  ADDRESS_WIDTH  shared bus address.
REQ-015 we_o  output  1  shared bus write strobe.
REQ-016 data_o  output  DATA_WIDTH  shared bus write data.
REQ-017 data_i  input  DATA_WIDTH  shared bus read data, valid READ_LATENCY cycles after the address cycle.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ACCESS and WAIT.
REQ-020 In IDLE with any mN_req_i high, the FSM SHALL register the winner, address, we and wdata, and SHALL enter ACCESS next cycle.
REQ-021 In ACCESS, address_o/data_o SHALL drive the registered values, we_o SHALL equal the registered we, and the winner's mN_gnt_o SHALL be 1.
REQ-022 After ACCESS, a write SHALL go to IDLE and a read SHALL go to WAIT.
REQ-023 WAIT SHALL last until data_i is sampled in cycle ACCESS+READ_LATENCY; that value SHALL go into the winner's mN_rdata_o.
REQ-024 After the sample, the FSM SHALL go to IDLE, and mN_rvalid_o SHALL pulse in cycle ACCESS+READ_LATENCY+1.
REQ-025 With READ_LATENCY=1, the FSM SHALL skip WAIT entirely: ACCESS samples data_i on the following cycle while the FSM is returning to IDLE.
REQ-026 The wait counter SHALL be 3 bits; it SHALL load in ACCESS and SHALL never wrap.
REQ-027 Arbitration SHALL be round-robin on a last_grant bit: with both requests high, the master not granted last SHALL win; with one request high, that master SHALL win.
REQ-028 last_grant SHALL update only on a grant.
REQ-029 Fairness: a continuously requesting master SHALL be granted within one foreign transaction.
REQ-030 Requests arriving outside IDLE SHALL be ignored until IDLE, and SHALL not be lost while held.
REQ-031 An rvalid pulse and a new IDLE decision SHALL be allowed in the same cycle.
REQ-032 Back-to-back writes SHALL use 2 cycles each; reads SHALL use READ_LATENCY+1 cycles each.
REQ-033 Outside ACCESS, we_o SHALL be 0, and address_o/data_o SHALL hold their last driven values.
REQ-034 The non-winning master SHALL see no gnt and no rvalid.

Reset
REQ-035 When reset_i=1 at a clock edge, the following SHALL all be 0 on the next cycle: FSM=IDLE, address_o, data_o, we_o, all gnt/rvalid, all rdata, busy_o, counter.
REQ-036 After reset, last_grant SHALL be 1, so m0 wins the first tie.
REQ-037 Reset during ACCESS or WAIT SHALL abandon the transaction with no gnt/rvalid afterward; the requester re-issues.

Verification
REQ-038 After reset, m0 write addr 0x10 data 0xA5 -> ACCESS next cycle: address_o=0x10, data_o=0xA5, we_o=1, m0_gnt_o=1; idle again 1 cycle later.
REQ-039 READ_LATENCY=3, m1 read addr 0x20, bus returns 0x1234 at ACCESS+3 -> m1_rvalid_o pulse at ACCESS+4 with m1_rdata_o=0x1234, m0_rvalid_o=0.
REQ-040 Both request continuously from reset -> grants alternate m0,m1,m0,m1; neither master waits more than one transaction.
REQ-041 m1 asserts req during m0 read WAIT -> m1 gnt in first ACCESS after m0 rvalid; m1 request not dropped.
REQ-042 Reset asserted in WAIT of an m0 read -> no m0_rvalid_o, all outputs 0, busy_o=0 next cycle; next tie goes to m0.
REQ-043 READ_LATENCY=1 back-to-back reads by m0 -> one rvalid every 2 cycles with correct data each time.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter for a single shared bus. It supports single-cycle
// address phases and reads that return data a fixed number of cycles later.
module bus_master_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     m0_req_i,
    input  logic                     m0_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0]    m0_wdata_i,
    output logic                     m0_gnt_o,
    output logic                     m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]    m0_rdata_o,
    input  logic                     m1_req_i,
    input  logic                     m1_we_i,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0]    m1_wdata_i,
    output logic                     m1_gnt_o,
    output logic                     m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]    m1_rdata_o,
    output logic [ADDRESS_WIDTH-1:0] address_o,
    output logic                     we_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

    // WAIT covers the cycles strictly between ACCESS and the sample cycle.
    localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_winner;
    logic                     r_last_grant;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [2:0]               r_cnt;
    logic                     r_rd_pend;
    logic [1:0]               r_rvalid;
    logic [DATA_WIDTH-1:0]    r_rdata0;
    logic [DATA_WIDTH-1:0]    r_rdata1;
    logic                     w_any_req;
    logic                     w_winner;
    logic                     w_sample;

    always_comb begin
        w_next_state = r_state;
        w_any_req    = m0_req_i | m1_req_i;
        // On a tie the master not granted last wins; otherwise the lone requester.
        w_winner     = (m0_req_i & m1_req_i) ? ~r_last_grant : m1_req_i;
        w_sample     = (r_state == IDLE) && r_rd_pend;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ACCESS;
            ACCESS:  if (r_we || (LAT_M1 == 3'd0)) w_next_state = IDLE;
                     else                          w_next_state = WAIT;
            WAIT:    if (r_cnt <= 3'd1) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_winner     <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= 3'd0;
            r_rd_pend    <= 1'b0;
            r_rvalid     <= 2'b00;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state   <= w_next_state;
            // A read's data is due in the first IDLE cycle after ACCESS/WAIT.
            r_rd_pend <= (r_state != IDLE) && (w_next_state == IDLE) && !r_we;
            r_rvalid  <= 2'b00;
            if (w_sample) begin
                r_rvalid[r_winner] <= 1'b1;
                if (r_winner) r_rdata1 <= data_i;
                else          r_rdata0 <= data_i;
            end
            if ((r_state == IDLE) && w_any_req) begin
                r_winner     <= w_winner;
                r_last_grant <= w_winner;
                r_we         <= w_winner ? m1_we_i    : m0_we_i;
                r_addr       <= w_winner ? m1_addr_i  : m0_addr_i;
                r_wdata      <= w_winner ? m1_wdata_i : m0_wdata_i;
            end
            if (r_state == ACCESS) begin
                r_cnt <= LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign m0_gnt_o    = (r_state == ACCESS) && !r_winner;
    assign m1_gnt_o    = (r_state == ACCESS) &&  r_winner;
    assign m0_rvalid_o = r_rvalid[0];
    assign m1_rvalid_o = r_rvalid[1];
    assign m0_rdata_o  = r_rdata0;
    assign m1_rdata_o  = r_rdata1;
    assign address_o   = r_addr;
    assign data_o      = r_wdata;
    assign we_o        = (r_state == ACCESS) && r_we;
    assign busy_o      = (r_state != IDLE);

endmodule
